// File: rtl/mov_sequencer.sv
// -----------------------------------------------------------------------------
// mov_sequencer
//   Register-move controller for the microcontroller datapath. Decodes MOV
//   instructions and sequences one-hot read enables (rx_out) and write
//   enables (rx_in) over NUM_REGS general registers. It also pulses pc_inc and
//   done for the top-level control path.
//
//   Operands are latched on the start edge, so instruction-bus changes during
//   a move have no effect. Out-of-range register indices are flagged on err.
//   Every output is a registered Moore decode of the state being entered.
//
//   Optional feature macro: MOV_SWAP_EN
//     When defined, dst field[5]=1 selects a register swap through the temp
//     register (FETCH -> SAVE -> XFER -> REST -> DONE).
//     When undefined, field[5] is ignored and tmp_ld/tmp_oe are constant 0.
//
// Parameters
//   NUM_REGS     number of general registers (2..32); width of rx_out/rx_in
//   OPCODE       instruction[15:12] value that selects this block
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   instr_valid  in   instruction valid this cycle
//   instruction  in   [15:12] opcode, [11:6] dst field, [5:0] src field
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse, move complete
//   err          out  pulses with done when src or dst index >= NUM_REGS
//   pc_inc       out  one-cycle pulse, program-counter increment
//   rx_out       out  one-hot register read enable (reg 0 = MSB)
//   rx_in        out  one-hot register write enable (reg 0 = MSB)
//   tmp_ld       out  load temp register from bus (swap only)
//   tmp_oe       out  drive temp register onto bus (swap only)
// -----------------------------------------------------------------------------
module mov_sequencer #(
  parameter int          NUM_REGS = 4,
  parameter logic [3:0]  OPCODE   = 4'b0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [15:0]         instruction,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                pc_inc,
  output logic [NUM_REGS-1:0] rx_out,
  output logic [NUM_REGS-1:0] rx_in,
  output logic                tmp_ld,
  output logic                tmp_oe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SAVE  = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_REST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [4:0] src_q, src_d;
  logic [4:0] dst_q, dst_d;
  logic       swap_q, swap_d;

  logic                busy_d, done_d, err_d, pc_inc_d, tmp_ld_d, tmp_oe_d;
  logic [NUM_REGS-1:0] rx_out_d, rx_in_d;

  logic                is_mov;
  logic                ops_ok;
  logic [NUM_REGS-1:0] oh_a;
  logic [NUM_REGS-1:0] oh_b;

  // Reserved src field[5], and dst field[5] in builds without swap.
  logic unused_bits;
  assign unused_bits = &{1'b0, instruction[5], instruction[11]};

  // Register i drives one-hot bit NUM_REGS-1-i.
  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [4:0] idx);
    logic [NUM_REGS-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      res[i] = (idx == 5'(NUM_REGS - 1 - i));
    end
    return res;
  endfunction

  function automatic logic idx_legal(input logic [4:0] idx);
    return ({1'b0, idx} < 6'(NUM_REGS));
  endfunction

  assign is_mov = instr_valid && (instruction[15:12] == OPCODE);

  // State, operand and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      swap_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      pc_inc  <= 1'b0;
      tmp_ld  <= 1'b0;
      tmp_oe  <= 1'b0;
      rx_out  <= '0;
      rx_in   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      swap_q  <= swap_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      pc_inc  <= pc_inc_d;
      tmp_ld  <= tmp_ld_d;
      tmp_oe  <= tmp_oe_d;
      rx_out  <= rx_out_d;
      rx_in   <= rx_in_d;
    end
  end

  // Next state and operand latch. Operands are captured only on the start
  // edge; the instruction bus is ignored afterwards until HOLD.
  always_comb begin
    state_d = S_IDLE;
    src_d   = src_q;
    dst_d   = dst_q;
    swap_d  = swap_q;
    case (state_q)
      S_IDLE: begin
        if (is_mov) begin
          state_d = S_FETCH;
          src_d   = instruction[4:0];
          dst_d   = instruction[10:6];
`ifdef MOV_SWAP_EN
          swap_d  = instruction[11];
`else
          swap_d  = 1'b0;
`endif
        end
      end
      S_FETCH: state_d = swap_q ? S_SAVE : S_XFER;
      S_SAVE:  state_d = S_XFER;
      S_XFER:  state_d = swap_q ? S_REST : S_DONE;
      S_REST:  state_d = S_DONE;
      S_DONE:  state_d = S_HOLD;
      // A held MOV must not re-execute: wait for a non-MOV/invalid cycle.
      S_HOLD:  state_d = is_mov ? S_HOLD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered and its operands, then
  // registered, so they change exactly on the edge that enters each state.
  // A = dst, B = src. A copy moves B into A; a swap parks B in temp first.
  assign ops_ok = idx_legal(src_d) && idx_legal(dst_d);
  assign oh_a   = idx_onehot(dst_d);
  assign oh_b   = idx_onehot(src_d);

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    err_d    = 1'b0;
    pc_inc_d = 1'b0;
    tmp_ld_d = 1'b0;
    tmp_oe_d = 1'b0;
    rx_out_d = '0;
    rx_in_d  = '0;
    case (state_d)
      S_FETCH: begin
        pc_inc_d = 1'b1;
        if (ops_ok) rx_out_d = oh_b;
      end
      S_SAVE: begin
        if (ops_ok) begin
          rx_out_d = oh_b;
          tmp_ld_d = 1'b1;
        end
      end
      S_XFER: begin
        if (ops_ok) begin
          if (swap_d) begin
            rx_out_d = oh_a;
            rx_in_d  = oh_b;
          end else begin
            rx_out_d = oh_b;
            rx_in_d  = oh_a;
          end
        end
      end
      S_REST: begin
        if (ops_ok) begin
          tmp_oe_d = 1'b1;
          rx_in_d  = oh_a;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = !ops_ok;
      end
      default: ;
    endcase
`ifdef MOV_SWAP_EN
`else
    tmp_ld_d = 1'b0;
    tmp_oe_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mov_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mov_sequencer
//   Scoreboard bench for mov_sequencer (NUM_REGS=4). Each driven cycle pushes
//   the output vector expected after the following rising edge; a monitor
//   pops and compares shortly after each edge. Swap expectations follow the
//   MOV_SWAP_EN macro.
// -----------------------------------------------------------------------------
module tb_mov_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instruction = '0;
  logic        busy, done, err, pc_inc, tmp_ld, tmp_oe;
  logic [3:0]  rx_out, rx_in;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  mov_sequencer #(.NUM_REGS(4), .OPCODE(4'b0100)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .busy(busy), .done(done), .err(err), .pc_inc(pc_inc),
    .rx_out(rx_out), .rx_in(rx_in), .tmp_ld(tmp_ld), .tmp_oe(tmp_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // {busy, done, err, pc_inc, tmp_ld, tmp_oe, rx_out, rx_in}
  function automatic logic [31:0] ev(input logic b, input logic d, input logic e,
                                     input logic p, input logic l, input logic o,
                                     input logic [3:0] ro, input logic [3:0] ri);
    return {22'd0, b, d, e, p, l, o, ro, ri};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {22'd0, busy, done, err, pc_inc, tmp_ld, tmp_oe, rx_out, rx_in};
  endfunction

  // Drive one cycle of input and record the output expected after the edge.
  task automatic step(input string tag, input logic v, input logic [15:0] ins,
                      input logic [31:0] exp);
    @(negedge clk);
    instr_valid = v;
    instruction = ins;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) check(tag_q.pop_front(), obs_vec(), exp_q.pop_front());
  end

  localparam logic [31:0] IDLE_V = 32'd0;

  initial begin
    logic [31:0] hold_v;
    hold_v = ev(1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

    // Reset state
    #1;
    check("reset_outs", obs_vec(), IDLE_V);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Non-MOV opcode is ignored
    step("nonmov", 1, 16'h3041, IDLE_V);
    step("nonmov_idle", 0, 16'h0000, IDLE_V);

    // src == dst, valid one cycle
    step("t1_fetch", 1, 16'h4041, ev(1, 0, 0, 1, 0, 0, 4'b0100, 4'b0000));
    step("t1_xfer",  0, 16'h0000, ev(1, 0, 0, 0, 0, 0, 4'b0100, 4'b0100));
    step("t1_done",  0, 16'h0000, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    step("t1_hold",  0, 16'h0000, hold_v);
    step("t1_idle",  0, 16'h0000, IDLE_V);

    // Held MOV (dst0, src3): executes once, stays in HOLD
    step("t2_fetch", 1, 16'h4003, ev(1, 0, 0, 1, 0, 0, 4'b0001, 4'b0000));
    step("t2_xfer",  1, 16'h4003, ev(1, 0, 0, 0, 0, 0, 4'b0001, 4'b1000));
    step("t2_done",  1, 16'h4003, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    for (int i = 0; i < 7; i++) step("t2_hold", 1, 16'h4003, hold_v);
    step("t2_idle",  0, 16'h4003, IDLE_V);

    // Illegal src 5
    step("t3_fetch", 1, 16'h4005, ev(1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    step("t3_xfer",  0, 16'h0000, hold_v);
    step("t3_done",  0, 16'h0000, ev(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000));
    step("t3_hold",  0, 16'h0000, hold_v);
    step("t3_idle",  0, 16'h0000, IDLE_V);

    // Boundary: src 4 == NUM_REGS is illegal
    step("src4_fetch", 1, 16'h4004, ev(1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    step("src4_xfer",  0, 16'h0000, hold_v);
    step("src4_done",  0, 16'h0000, ev(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000));
    step("src4_hold",  0, 16'h0000, hold_v);
    step("src4_idle",  0, 16'h0000, IDLE_V);

    // Illegal dst 5, legal src 0
    step("dst5_fetch", 1, 16'h4140, ev(1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    step("dst5_xfer",  0, 16'h0000, hold_v);
    step("dst5_done",  0, 16'h0000, ev(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000));
    step("dst5_hold",  0, 16'h0000, hold_v);
    step("dst5_idle",  0, 16'h0000, IDLE_V);

    // Instruction changes after start: operands stay src2/dst1
    step("t4_fetch", 1, 16'h4042, ev(1, 0, 0, 1, 0, 0, 4'b0010, 4'b0000));
    step("t4_xfer",  1, 16'h4000, ev(1, 0, 0, 0, 0, 0, 4'b0010, 4'b0100));
    step("t4_done",  1, 16'h4000, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    step("t4_hold",  1, 16'h4000, hold_v);
    step("t4_idle",  0, 16'h0000, IDLE_V);

    // Reserved src field[5] is ignored: src field 6'b100001 is reg 1
    step("srcr_fetch", 1, 16'h4021, ev(1, 0, 0, 1, 0, 0, 4'b0100, 4'b0000));
    step("srcr_xfer",  0, 16'h0000, ev(1, 0, 0, 0, 0, 0, 4'b0100, 4'b1000));
    step("srcr_done",  0, 16'h0000, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    step("srcr_hold",  0, 16'h0000, hold_v);
    step("srcr_idle",  0, 16'h0000, IDLE_V);

    // Swap flag: A=1, B=3
`ifdef MOV_SWAP_EN
    step("t6_fetch", 1, 16'h4843, ev(1, 0, 0, 1, 0, 0, 4'b0001, 4'b0000));
    step("t6_save",  0, 16'h0000, ev(1, 0, 0, 0, 1, 0, 4'b0001, 4'b0000));
    step("t6_xfer",  0, 16'h0000, ev(1, 0, 0, 0, 0, 0, 4'b0100, 4'b0001));
    step("t6_rest",  0, 16'h0000, ev(1, 0, 0, 0, 0, 1, 4'b0000, 4'b0100));
    step("t6_done",  0, 16'h0000, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    step("t6_hold",  0, 16'h0000, hold_v);
    step("t6_idle",  0, 16'h0000, IDLE_V);
    // Illegal swap: no enables, no temp strobes
    step("swe_fetch", 1, 16'h4845, ev(1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    step("swe_save",  0, 16'h0000, hold_v);
    step("swe_xfer",  0, 16'h0000, hold_v);
    step("swe_rest",  0, 16'h0000, hold_v);
    step("swe_done",  0, 16'h0000, ev(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000));
    step("swe_hold",  0, 16'h0000, hold_v);
    step("swe_idle",  0, 16'h0000, IDLE_V);
`else
    step("t6_fetch", 1, 16'h4843, ev(1, 0, 0, 1, 0, 0, 4'b0001, 4'b0000));
    step("t6_xfer",  0, 16'h0000, ev(1, 0, 0, 0, 0, 0, 4'b0001, 4'b0100));
    step("t6_done",  0, 16'h0000, ev(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000));
    step("t6_hold",  0, 16'h0000, hold_v);
    step("t6_idle",  0, 16'h0000, IDLE_V);
    step("swe_fetch", 1, 16'h4845, ev(1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000));
    step("swe_xfer",  0, 16'h0000, hold_v);
    step("swe_done",  0, 16'h0000, ev(1, 1, 1, 0, 0, 0, 4'b0000, 4'b0000));
    step("swe_hold",  0, 16'h0000, hold_v);
    step("swe_idle",  0, 16'h0000, IDLE_V);
`endif

    // Asynchronous reset in XFER aborts immediately
    step("t5_fetch", 1, 16'h4041, ev(1, 0, 0, 1, 0, 0, 4'b0100, 4'b0000));
    step("t5_xfer",  0, 16'h0000, ev(1, 0, 0, 0, 0, 0, 4'b0100, 4'b0100));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_rst", obs_vec(), IDLE_V);
    @(negedge clk);
    rst = 1'b0;
    step("t5_after1", 0, 16'h0000, IDLE_V);
    step("t5_after2", 0, 16'h0000, IDLE_V);
    step("t5_after3", 0, 16'h0000, IDLE_V);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
